bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Round-robin arbiter and data/control multiplexer for the shared 32-bit system bus. It accepts up to eight master/slave `req` lines. It grants one requester at a time through a one-hot `ack` and drives that requester's data and control words onto the common bus. It replaces the fixed-priority bus controller where several masters (test master, CPU, DMA) share the async SRAM controller. It inserts a one-cycle turnaround between owners so that no two drivers overlap.

## Interface
- `BUS_WIDTH`, 32, width of each data word.
- `CTRL_WIDTH`, 8, width of each control word.
- `N_REQ`, 8, number of requesters; fixed at 8 (3-bit grant index).
- `MAX_HOLD`, 64, maximum consecutive grant cycles. Used only when the timeout feature is compiled in.

Ports:
- `clk50MHz`  in  1  system clock; all logic is on the rising edge.
- `rst_L`  in  1  reset; synchronous, active-low.
- `req`  in  8  request per requester; level-sensitive; held high for the whole transfer.
- `bus_in`  in  8*BUS_WIDTH  data word of requester i in bits [i*BUS_WIDTH +: BUS_WIDTH].
- `ctrl_in`  in  8*CTRL_WIDTH  control word of requester i, packed the same way.
- `ack`  out  8  one-hot grant, registered.
- `bus_out`  out  BUS_WIDTH  shared bus data.
- `ctrl_out`  out  CTRL_WIDTH  shared bus control.
- `grant_id`  out  3  index of the current owner; valid while `busy`=1.
- `busy`  out  1  high while any `ack` bit is high.
- `timeout`  out  1  one-cycle pulse when a grant is revoked. Present only with `BUS_ARB_TIMEOUT_EN`.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: `ack[g]`=1.
  - TURN: one dead cycle with all `ack`=0.
- Round-robin pointer `ptr` (3 bits):
  - Reset value 0.
  - On each grant, `ptr` becomes (g+1) mod 8.
- Winner selection: the first `i` with `req[i]`=1, searching `ptr`, `ptr`+1, …, `ptr`+7 (mod 8).
- IDLE:
  - If `req`≠0, latch g = winner and go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT:
  - If `req[g]`=0, go to TURN.
  - Requests from other indices are ignored while `req[g]` stays high (no preemption).
- TURN:
  - Always goes to IDLE on the next cycle.
  - A request present at that point is arbitrated normally.
- Mux:
  - In GRANT, `bus_out` = `bus_in[g]` and `ctrl_out` = `ctrl_in[g]`. The mux is combinational from the registered g and the state.
  - In IDLE and TURN, `bus_out`=0 and `ctrl_out`=0.
- Simultaneous requests: resolved strictly by `ptr` order. After reset, requester 0 wins ties.
- Reset mid-grant: the next edge with `rst_L`=0 clears all outputs, `ptr`=0 and the FSM to IDLE. No transfer state is preserved.

## Timing
- Request latency: `req[i]` sampled high at edge N (FSM in IDLE) gives `ack[i]`=1 after edge N+1. This is one cycle.
- Release:
  - `req[g]` sampled low at edge M gives `ack[g]`=0 after M+1, and the FSM is in TURN after M+1.
  - The earliest next `ack` is after edge M+3.
- Back-to-back owners therefore see a minimum gap of 2 cycles with all `ack` low.
- Reset values: `ack`=0, `bus_out`=0, `ctrl_out`=0, `grant_id`=0, `busy`=0, `timeout`=0.
- `busy` and `grant_id` are registered together with `ack`.

## Configuration
- Macro: `BUS_ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 while `req[g]` is still high, the FSM forces the GRANT→TURN transition and pulses `timeout` for one cycle, coincident with `ack` falling.
  - `ptr` has already advanced past g, so another pending requester wins next. If none is pending, g is regranted.
- When undefined: no counter and no `timeout` port. A grant lasts until `req[g]` falls.

## Structure
- A shared package `bus_pkg` holds:
  - `BUS_WIDTH` and `CTRL_WIDTH` defaults.
  - The FSM state enum {IDLE, GRANT, TURN}.
  - `N_REQ`.
- One sub-module, `rr_pick8`:
  - Combinational.
  - Inputs: `req[7:0]` and `ptr[2:0]`.
  - Outputs: `found` and `idx[2:0]`.
  - Reused by future interrupt arbitration.

## Test plan
- Reset: hold `rst_L`=0 for 3 cycles with `req`=8'hFF. All outputs are 0. On release, `ack`=8'h01 one cycle after the first sampled edge.
- Single owner: `req[7]`=1 with `bus_in[7]`=32'hDEADBEEF and `ctrl_in[7]`=8'h5A.
  - `ack`=8'h80 after 1 cycle, and `bus_out`/`ctrl_out` match the inputs.
  - Drop `req[7]`: `ack`=0 and `bus_out`=0 on the next cycle.
- Fairness: with `req`=8'h81 held continuously and each owner dropping its request for 1 cycle after 4 cycles, the grant order is 0,7,0,7 with a 2-cycle gap between grants.
- No preemption: requester 3 is granted; raise `req[1]`. `ack` stays 8'h08 until `req[3]` falls, then becomes 8'h02 two cycles later.
- Mid-grant reset: pulse `rst_L`=0 for 1 cycle while requester 5 is granted. The next cycle gives `ack`=0, then `ack`=8'h20 again if `req[5]` is still high (`ptr`=0, scan finds 5).
- Timeout (with macro, MAX_HOLD=4): hold `req`=8'h03 continuously.
  - `ack[0]` lasts 4 cycles, then `timeout`=1 for 1 cycle.
  - `ack[1]` follows after 2 cycles, and `ack[0]` and `ack[1]` then alternate.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: default word widths, requester count, arbiter FSM states.
// Latency: none (type and constant definitions only).
// Backpressure: none.
package bus_pkg;

  localparam int BUS_WIDTH  = 32;
  localparam int CTRL_WIDTH = 8;
  localparam int N_REQ      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request bit scanning from ptr upward, modulo 8.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set (idx is then 0).
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] cand;

  // Scan from ptr+7 down to ptr so the lowest rotated offset is the last (winning) assignment.
  always_comb begin
    found = |req;
    idx   = 3'd0;
    cand  = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + k[2:0];
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter and data/control mux for the shared bus, with a dead turnaround cycle.
// Latency: request to ack one cycle; release to next ack at least three cycles (two all-low cycles).
// Backpressure: an owner keeps the bus while its req stays high; BUS_ARB_TIMEOUT_EN adds a hold limit.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH  = bus_pkg::BUS_WIDTH,
  parameter int CTRL_WIDTH = bus_pkg::CTRL_WIDTH,
  parameter int N_REQ      = bus_pkg::N_REQ,
  parameter int MAX_HOLD   = 64
) (
  input  logic                        clk50MHz,
  input  logic                        rst_L,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*BUS_WIDTH-1:0]  bus_in,
  input  logic [N_REQ*CTRL_WIDTH-1:0] ctrl_in,
  output logic [N_REQ-1:0]            ack,
  output logic [BUS_WIDTH-1:0]        bus_out,
  output logic [CTRL_WIDTH-1:0]       ctrl_out,
  output logic [2:0]                  grant_id,
  output logic                        busy
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic                        timeout
`endif
);

  // The grant index is 3 bits wide and the hold limit must allow at least one retained cycle.
  if (N_REQ != 8) begin : g_bad_nreq
    $error("bus_arbiter_rr supports exactly 8 requesters");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("bus_arbiter_rr MAX_HOLD must be at least 2");
  end

  state_t     state, state_nxt;
  logic [2:0] g;
  logic [2:0] ptr;
  logic       found;
  logic [2:0] win_idx;
  logic       take_grant;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (win_idx)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expire;
`endif

  // Next-state logic: grant from IDLE, release on req drop (or hold expiry), one dead TURN cycle.
  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_expire = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = GRANT;
          take_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req[g]) begin
          state_nxt = TURN;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
          state_nxt   = TURN;
          hold_expire = 1'b1;
        end
`endif
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner, pointer and registered grant outputs; reset discards any transfer in flight.
  always_ff @(posedge clk50MHz) begin
    if (!rst_L) begin
      state    <= IDLE;
      g        <= 3'd0;
      ptr      <= 3'd0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= 3'd0;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        g        <= win_idx;
        ptr      <= win_idx + 3'd1;
        grant_id <= win_idx;
        ack      <= N_REQ'(1) << win_idx;
        busy     <= 1'b1;
      end else if (state_nxt != GRANT) begin
        ack  <= '0;
        busy <= 1'b0;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Hold counter restarts on each grant; timeout pulses in the cycle ack falls due to expiry.
  always_ff @(posedge clk50MHz) begin
    if (!rst_L) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= hold_expire;
      if (take_grant) begin
        hold_cnt <= '0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`endif

  // Owner's words go onto the bus only while granted; the bus is parked at zero otherwise.
  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    if (state == GRANT) begin
      bus_out  = bus_in[g*BUS_WIDTH +: BUS_WIDTH];
      ctrl_out = ctrl_in[g*CTRL_WIDTH +: CTRL_WIDTH];
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios then random traffic against an owner/gap/pointer model.
// Latency: model advances once per rising edge; outputs compared on the falling edge.
// Backpressure: not applicable; BUS_ARB_TIMEOUT_EN also enables the hold-limit checks.
module tb_bus_arbiter_rr;

  localparam int BW = 32;
  localparam int CW = 8;
  localparam int NR = 8;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [NR-1:0]     req;
  logic [BW-1:0]     din [NR];
  logic [CW-1:0]     cin [NR];
  logic [NR*BW-1:0]  bus_flat;
  logic [NR*CW-1:0]  ctrl_flat;
  logic [NR-1:0]     ack;
  logic [BW-1:0]     bus_out;
  logic [CW-1:0]     ctrl_out;
  logic [2:0]        grant_id;
  logic              busy;
`ifdef BUS_ARB_TIMEOUT_EN
  logic              timeout;
`endif

  always #10 clk = ~clk;

  always_comb begin
    bus_flat  = '0;
    ctrl_flat = '0;
    for (int i = 0; i < NR; i++) begin
      bus_flat[i*BW +: BW]  = din[i];
      ctrl_flat[i*CW +: CW] = cin[i];
    end
  end

  bus_arbiter_rr #(.BUS_WIDTH(BW), .CTRL_WIDTH(CW), .N_REQ(NR), .MAX_HOLD(MAX_HOLD)) dut (
    .clk50MHz (clk),
    .rst_L    (rst_l),
    .req      (req),
    .bus_in   (bus_flat),
    .ctrl_in  (ctrl_flat),
    .ack      (ack),
    .bus_out  (bus_out),
    .ctrl_out (ctrl_out),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef BUS_ARB_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: current owner (-1 = none), dead cycles left before arbitration, rotating start.
  int owner = -1;
  int gap   = 0;
  int rr    = 0;
  int held  = 0;
  bit exp_to = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    exp_to = 1'b0;
    if (!rst_l) begin
      owner = -1; gap = 0; rr = 0; held = 0;
      return;
    end
    if (owner >= 0) begin
      if (!req[owner]) begin
        owner = -1; gap = 1;
      end
`ifdef BUS_ARB_TIMEOUT_EN
      else if (held == MAX_HOLD) begin
        owner = -1; gap = 1; exp_to = 1'b1;
      end
`endif
      else held++;
    end else if (gap > 0) begin
      gap--;
    end else if (req != 0) begin
      for (int k = 0; k < NR; k++) begin
        if (req[(rr + k) % NR]) begin
          owner = (rr + k) % NR;
          break;
        end
      end
      rr = (owner + 1) % NR;
      held = 1;
    end
  endtask

  task automatic step(input string tag);
    logic [NR-1:0] e_ack;
    logic [BW-1:0] e_bus;
    logic [CW-1:0] e_ctl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e_ack = '0; e_bus = '0; e_ctl = '0;
    if (owner >= 0) begin
      e_ack[owner] = 1'b1;
      e_bus = din[owner];
      e_ctl = cin[owner];
    end
    check({tag, ".ack"}, 64'(ack), 64'(e_ack));
    check({tag, ".busy"}, 64'(busy), 64'(owner >= 0));
    check({tag, ".bus"}, 64'(bus_out), 64'(e_bus));
    check({tag, ".ctrl"}, 64'(ctrl_out), 64'(e_ctl));
    if (owner >= 0) check({tag, ".gid"}, 64'(grant_id), 64'(owner));
`ifdef BUS_ARB_TIMEOUT_EN
    check({tag, ".timeout"}, 64'(timeout), 64'(exp_to));
`endif
  endtask

  initial begin
    int order[$];
    int gaps[$];
    int zero_run;
    logic [NR-1:0] prev_ack;
    logic [NR-1:0] flip;

    for (int i = 0; i < NR; i++) begin
      din[i] = $urandom();
      cin[i] = CW'($urandom());
    end

    // Reset held with every requester asking; outputs stay zero, requester 0 wins on release.
    rst_l = 1'b0;
    req   = 8'hFF;
    for (int i = 0; i < 3; i++) step("reset");
    check("reset.ack0", 64'(ack), 64'h0);
    check("reset.gid0", 64'(grant_id), 64'h0);
    check("reset.bus0", 64'(bus_out), 64'h0);
    rst_l = 1'b1;
    step("release");
    check("release.ack", 64'(ack), 64'h01);
    req = 8'h00;
    for (int i = 0; i < 3; i++) step("settle");

    // Single owner on requester 7.
    din[7] = 32'hDEADBEEF;
    cin[7] = 8'h5A;
    req = 8'h80;
    step("single");
    check("single.ack", 64'(ack), 64'h80);
    check("single.bus", 64'(bus_out), 64'hDEADBEEF);
    check("single.ctrl", 64'(ctrl_out), 64'h5A);
    req = 8'h00;
    step("single_drop");
    check("single_drop.ack", 64'(ack), 64'h0);
    check("single_drop.bus", 64'(bus_out), 64'h0);
    for (int i = 0; i < 3; i++) step("settle");

    // Fairness: 0 and 7 both pending; each owner drops its request for one cycle after four grant cycles.
    req = 8'h81;
    prev_ack = '0;
    zero_run = 0;
    for (int i = 0; i < 30; i++) begin
      if (owner >= 0 && held == 4) req[owner] = 1'b0;
      step("fair");
      req = 8'h81;
      if (ack != 0 && prev_ack == 0) begin
        order.push_back($clog2(ack));
        gaps.push_back(zero_run);
      end
      zero_run = (ack == 0) ? zero_run + 1 : 0;
      prev_ack = ack;
    end
    check("fair.count", 64'(order.size() >= 4), 64'h1);
    if (order.size() >= 4) begin
      check("fair.g0", 64'(order[0]), 64'd0);
      check("fair.g1", 64'(order[1]), 64'd7);
      check("fair.g2", 64'(order[2]), 64'd0);
      check("fair.g3", 64'(order[3]), 64'd7);
      for (int i = 1; i < 4; i++) check("fair.gap", 64'(gaps[i]), 64'd2);
    end
    req = 8'h00;
    for (int i = 0; i < 4; i++) step("settle");

    // No preemption: requester 3 keeps the bus while requester 1 waits.
    req = 8'h08;
    step("nopre_grant");
    check("nopre_grant.ack", 64'(ack), 64'h08);
    req = 8'h0A;
    step("nopre_hold");
    check("nopre_hold1.ack", 64'(ack), 64'h08);
    step("nopre_hold");
    check("nopre_hold2.ack", 64'(ack), 64'h08);
    req = 8'h02;
    step("nopre_rel");
    check("nopre_rel.ack", 64'(ack), 64'h0);
    step("nopre_idle");
    check("nopre_idle.ack", 64'(ack), 64'h0);
    step("nopre_next");
    check("nopre_next.ack", 64'(ack), 64'h02);
    req = 8'h00;
    for (int i = 0; i < 4; i++) step("settle");

    // Mid-grant reset while requester 5 owns the bus.
    req = 8'h20;
    step("mid_grant");
    check("mid_grant.ack", 64'(ack), 64'h20);
    rst_l = 1'b0;
    step("mid_rst");
    check("mid_rst.ack", 64'(ack), 64'h0);
    rst_l = 1'b1;
    step("mid_regrant");
    check("mid_regrant.ack", 64'(ack), 64'h20);
    req = 8'h00;
    for (int i = 0; i < 4; i++) step("settle");

    // Two requesters held continuously: with the hold limit they alternate, otherwise 0 keeps the bus.
    req = 8'h03;
    for (int i = 0; i < 20; i++) step("hold");
    req = 8'h00;
    for (int i = 0; i < 4; i++) step("settle");

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      flip = '0;
      for (int b = 0; b < NR; b++) flip[b] = ($urandom_range(7) == 0);
      req = req ^ flip;
      for (int b = 0; b < NR; b++) begin
        din[b] = $urandom();
        cin[b] = CW'($urandom());
      end
      rst_l = ($urandom_range(99) != 0);
      step("rand");
    end
    rst_l = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
